// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_mp register file: FSM state encoding,
// default geometry and the even-parity helper used when REGFILE_PARITY_EN
// is defined.
package regfile_pkg;

  // Sweep FSM: INIT clears the array after reset, RUN serves user traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_W_DATA = 32;
  localparam int DEF_W_ADDR = 5;

  // Widest data word the parity helper accepts; narrower words are
  // zero-extended, which leaves the XOR reduction unchanged.
  localparam int MAX_W_DATA = 64;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [MAX_W_DATA-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle for regfile_mp: N_RD read ports, one write port, the Ready
// flag and (with REGFILE_PARITY_EN) per-port parity error flags.
// Signal suffixes are from the register file's (slave's) point of view.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_ADDR = DEF_W_ADDR,
  parameter int N_RD   = 2
);

  logic                     ready_o;
  logic [N_RD-1:0]          en_r_i;
  logic [N_RD*W_ADDR-1:0]   addr_r_i;
  logic [N_RD*W_DATA-1:0]   data_r_o;
  logic                     en_w_i;
  logic [W_ADDR-1:0]        addr_w_i;
  logic [W_DATA-1:0]        data_w_i;
`ifdef REGFILE_PARITY_EN
  logic [N_RD-1:0]          parity_err_o;
`endif

  modport master (
    input  ready_o, data_r_o,
`ifdef REGFILE_PARITY_EN
    input  parity_err_o,
`endif
    output en_r_i, addr_r_i, en_w_i, addr_w_i, data_w_i
  );

  modport slave (
    output ready_o, data_r_o,
`ifdef REGFILE_PARITY_EN
    output parity_err_o,
`endif
    input  en_r_i, addr_r_i, en_w_i, addr_w_i, data_w_i
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp. Selects between the zero
// register, write-through bypass and the array value, and registers the
// result. With REGFILE_PARITY_EN the stored parity is checked on array
// reads and the error flag is registered alongside the data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_ADDR = DEF_W_ADDR,
  parameter int ZR_IDX = 2**W_ADDR - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic              en_r_i,
  input  logic [W_ADDR-1:0] addr_r_i,
  input  logic [W_DATA-1:0] row_data_i,
`ifdef REGFILE_PARITY_EN
  input  logic              row_par_i,
  output logic              parity_err_o,
`endif
  input  logic              en_w_i,
  input  logic [W_ADDR-1:0] addr_w_i,
  input  logic [W_DATA-1:0] data_w_i,
  output logic [W_DATA-1:0] data_r_o
);

  localparam logic [W_ADDR-1:0] ZR_ADDR = W_ADDR'(ZR_IDX);

  logic [W_DATA-1:0] data_d, data_q;
`ifdef REGFILE_PARITY_EN
  logic              perr_d, perr_q;
`endif

  // Next read value: hold unless enabled; INIT and zero register give 0,
  // then bypass, then the array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_d = data_q;
`ifdef REGFILE_PARITY_EN
    perr_d = perr_q;
`endif
    if (en_r_i) begin
      if (init_i || addr_r_i == ZR_ADDR) begin
        data_d = '0;
`ifdef REGFILE_PARITY_EN
        perr_d = 1'b0;
`endif
      end else if (en_w_i && addr_w_i == addr_r_i) begin
        data_d = data_w_i;
`ifdef REGFILE_PARITY_EN
        perr_d = 1'b0;
`endif
      end else begin
        data_d = row_data_i;
`ifdef REGFILE_PARITY_EN
        perr_d = row_par_i != even_parity(MAX_W_DATA'(row_data_i));
`endif
      end
    end
  end

  // Output register: one cycle of read latency, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    if (rst) begin
      data_q <= '0;
`ifdef REGFILE_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
`ifdef REGFILE_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign data_r_o = data_q;
`ifdef REGFILE_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file for the Kabeta decode stage.
// One write port, N_RD registered read ports, a hard-wired zero register
// at ZR_IDX and write-through bypass. After reset an INIT sweep clears
// every entry before Ready rises. Define REGFILE_PARITY_EN to store an
// even-parity bit per entry and report per-port parity errors.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_ADDR = DEF_W_ADDR,
  parameter int N_RD   = 2,
  parameter int ZR_IDX = 2**W_ADDR - 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int N_ENT = 2**W_ADDR;
`ifdef REGFILE_PARITY_EN
  localparam int W_ARR = W_DATA + 1;
`else
  localparam int W_ARR = W_DATA;
`endif
  localparam logic [W_ADDR-1:0] ZR_ADDR   = W_ADDR'(ZR_IDX);
  localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(N_ENT - 1);

  state_e            state_q;
  logic [W_ADDR-1:0] init_ptr_q;
  logic              ready_q;

  logic [W_ARR-1:0]  arr_q [N_ENT];

  logic              wr_en;
  logic [W_ADDR-1:0] wr_addr;
  logic [W_DATA-1:0] wr_data;

  logic [W_DATA-1:0] rd_data [N_RD];

  // Init sweep FSM: walk every index once after reset, then enter RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else if (state_q == INIT) begin
      init_ptr_q <= init_ptr_q + W_ADDR'(1);
      if (init_ptr_q == LAST_ADDR) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Write source: the sweep clears entries in INIT, user writes in RUN;
  // the zero register is never written.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_ptr_q;
    wr_data = '0;
    if (state_q == INIT) begin
      wr_en = (init_ptr_q != ZR_ADDR);
    end else if (bus.en_w_i && bus.addr_w_i != ZR_ADDR) begin
      wr_en   = 1'b1;
      wr_addr = bus.addr_w_i;
      wr_data = bus.data_w_i;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the INIT sweep clears it, which
    // keeps it mappable to plain RAM/flop arrays without a reset tree.
    if (wr_en) begin
`ifdef REGFILE_PARITY_EN
      arr_q[wr_addr] <= {even_parity(MAX_W_DATA'(wr_data)), wr_data};
`else
      arr_q[wr_addr] <= wr_data;
`endif
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [W_ADDR-1:0] addr;
    logic [W_ARR-1:0]  row;

    assign addr = bus.addr_r_i[p*W_ADDR +: W_ADDR];
    assign row  = arr_q[addr];

    regfile_read_port #(
      .W_DATA (W_DATA),
      .W_ADDR (W_ADDR),
      .ZR_IDX (ZR_IDX)
    ) u_port (
      .clk          (clk),
      .rst          (rst),
      .init_i       (state_q == INIT),
      .en_r_i       (bus.en_r_i[p]),
      .addr_r_i     (addr),
      .row_data_i   (row[W_DATA-1:0]),
`ifdef REGFILE_PARITY_EN
      .row_par_i    (row[W_DATA]),
      .parity_err_o (bus.parity_err_o[p]),
`endif
      .en_w_i       (bus.en_w_i),
      .addr_w_i     (bus.addr_w_i),
      .data_w_i     (bus.data_w_i),
      .data_r_o     (rd_data[p])
    );
  end

  // Pack per-port read data onto the bus.
  always_comb begin
    bus.data_r_o = '0;
    for (int p = 0; p < N_RD; p++) begin
      bus.data_r_o[p*W_DATA +: W_DATA] = rd_data[p];
    end
  end

  assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a reference model predicts each
// port's registered read result, pushes it to a scoreboard queue when the
// stimulus is driven, and pops/compares it after the clock edge.
module tb_regfile_mp;

  localparam int W_DATA = 32;
  localparam int W_ADDR = 5;
  localparam int N_RD   = 2;
  localparam int N_ENT  = 32;
  localparam int ZR     = 31;

  logic clk;
  logic rst;

  regfile_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_RD(N_RD)) bus ();

  regfile_mp #(
    .W_DATA (W_DATA),
    .W_ADDR (W_ADDR),
    .N_RD   (N_RD),
    .ZR_IDX (ZR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        perr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem     [N_ENT];
  logic        corrupt [N_ENT];
  logic [31:0] hold_d  [N_RD];
  logic        hold_p  [N_RD];
  int          init_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) begin
      mem[i]     = '0;
      corrupt[i] = 1'b0;
    end
    for (int p = 0; p < N_RD; p++) begin
      hold_d[p] = '0;
      hold_p[p] = 1'b0;
    end
    init_cnt = 0;
    sb_q.delete();
  endtask

  // Asserts reset (asynchronously, wherever the caller is in the cycle),
  // checks the outputs clear at once, then releases it on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(bus.ready_o), 64'(0));
    check({tag, "_data"}, 64'(bus.data_r_o), 64'(0));
`ifdef REGFILE_PARITY_EN
    check({tag, "_perr"}, 64'(bus.parity_err_o), 64'(0));
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus; called and returns on a falling edge.
  task automatic step(input logic [1:0] en_r, input logic [4:0] a0, input logic [4:0] a1,
                      input logic en_w, input logic [4:0] aw, input logic [31:0] dw);
    logic        run;
    logic [4:0]  a;
    exp_t        e;
    bus.en_r_i   = en_r;
    bus.addr_r_i = {a1, a0};
    bus.en_w_i   = en_w;
    bus.addr_w_i = aw;
    bus.data_w_i = dw;
    run = (init_cnt >= N_ENT);
    for (int p = 0; p < N_RD; p++) begin
      a      = (p == 0) ? a0 : a1;
      e.port = p;
      if (!en_r[p]) begin
        e.data = hold_d[p];
        e.perr = hold_p[p];
      end else if (!run || a == 5'(ZR)) begin
        e.data = '0;
        e.perr = 1'b0;
      end else if (en_w && aw == a) begin
        e.data = dw;
        e.perr = 1'b0;
      end else begin
        e.data = mem[a] ^ {31'b0, corrupt[a]};
        e.perr = corrupt[a];
      end
      hold_d[p] = e.data;
      hold_p[p] = e.perr;
      sb_q.push_back(e);
    end
    if (run && en_w && aw != 5'(ZR)) begin
      mem[aw]     = dw;
      corrupt[aw] = 1'b0;
    end
    @(posedge clk);
    if (!run) init_cnt++;
    #1;
    check("ready", 64'(bus.ready_o), 64'(init_cnt >= N_ENT));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("rd%0d", e.port), 64'(bus.data_r_o[e.port*32 +: 32]), 64'(e.data));
`ifdef REGFILE_PARITY_EN
      check($sformatf("perr%0d", e.port), 64'(bus.parity_err_o[e.port]), 64'(e.perr));
`endif
    end
    @(negedge clk);
  endtask

  task automatic sweep(input logic en_w, input logic [4:0] aw, input logic [31:0] dw);
    for (int i = 0; i < N_ENT; i++) step(2'b01, 5'd3, 5'd0, en_w, aw, dw);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en_r_i   = '0;
    bus.addr_r_i = '0;
    bus.en_w_i   = 1'b0;
    bus.addr_w_i = '0;
    bus.data_w_i = '0;

    // Power-on reset, then the full sweep with a user write that must be lost.
    do_reset("por");
    sweep(1'b1, 5'd5, 32'h0000_0099);

    // Every entry reads zero after Ready.
    for (int i = 0; i < N_ENT; i += 2) step(2'b11, 5'(i), 5'(i + 1), 1'b0, 5'd0, 32'h0);

    // Basic write then read.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'hDEAD_BEEF);
    step(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 32'h0);

    // Bypass on both ports, then a no-bypass read with EnW low.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hCAFE_F00D);
    step(2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234_5678);
    step(2'b11, 5'd7, 5'd7, 1'b0, 5'd7, 32'hFFFF_FFFF);

    // Zero register: dropped write, plain read, read with a same-cycle write.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd31, 32'hAAAA_5555);
    step(2'b11, 5'd31, 5'd31, 1'b0, 5'd0, 32'h0);
    step(2'b11, 5'd31, 5'd31, 1'b1, 5'd31, 32'hAAAA_5555);

    // Disabled ports hold while the array changes underneath.
    step(2'b00, 5'd7, 5'd7, 1'b1, 5'd7, 32'h0BAD_0BAD);
    step(2'b10, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      step(2'($urandom), 5'($urandom), 5'($urandom_range(28, 31)),
           1'($urandom), 5'($urandom_range(0, 31)), $urandom);
    end

    // Reset in RUN mid-cycle, then again at INIT cycle 10.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'h0000_0055);
    step(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    #2;
    do_reset("rst_run");
    for (int i = 0; i < 10; i++) step(2'b01, 5'd3, 5'd0, 1'b1, 5'd5, 32'h0000_0077);
    do_reset("rst_init");
    sweep(1'b1, 5'd5, 32'h0000_0066);
    step(2'b11, 5'd5, 5'd4, 1'b0, 5'd0, 32'h0);

`ifdef REGFILE_PARITY_EN
    // Corrupt a stored bit of r9; array read flags it, bypass and r10 do not.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0000_00F1);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd10, 32'h1234_0000);
    dut.arr_q[9][0] = ~dut.arr_q[9][0];
    corrupt[9] = 1'b1;
    step(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0);
    step(2'b01, 5'd9, 5'd0, 1'b1, 5'd9, 32'h0000_0077);
    step(2'b01, 5'd10, 5'd0, 1'b0, 5'd0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
